// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard_stall_ctrl bundle; master = pipeline side, slave = controller side.
// stall_cnt exists only when HAZARD_STALL_CNT_EN is defined.
interface hazard_stall_ctrl_if;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_tuse_rs;
  logic [1:0] D_tuse_rt;
  logic       D_is_md;
  logic [4:0] E_A3;
  logic [1:0] E_tnew;
  logic [4:0] M_A3;
  logic [1:0] M_tnew;
  logic       E_md_start;
  logic       E_md_is_div;
  logic       IFU_en;
  logic       F2D_en;
  logic       D2E_en;
  logic       E2M_en;
  logic       M2W_en;
  logic       flush;
  logic       md_busy;
  logic       md_done;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    output E_A3, E_tnew, M_A3, M_tnew, E_md_start, E_md_is_div,
    input  IFU_en, F2D_en, D2E_en, E2M_en, M2W_en, flush, md_busy, md_done,
    input  stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    input  E_A3, E_tnew, M_A3, M_tnew, E_md_start, E_md_is_div,
    output IFU_en, F2D_en, D2E_en, E2M_en, M2W_en, flush, md_busy, md_done,
    output stall_cnt
  );
`else
  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    output E_A3, E_tnew, M_A3, M_tnew, E_md_start, E_md_is_div,
    input  IFU_en, F2D_en, D2E_en, E2M_en, M2W_en, flush, md_busy, md_done
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    input  E_A3, E_tnew, M_A3, M_tnew, E_md_start, E_md_is_div,
    output IFU_en, F2D_en, D2E_en, E2M_en, M2W_en, flush, md_busy, md_done
  );
`endif
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall control for the F/D/E/M/W core: RAW (Tuse/Tnew) and mult/div stalls; HAZARD_STALL_CNT_EN adds stall_cnt.
// Enables/flush are combinational in the same cycle; md_busy/md_done are registered. A stall freezes PC and F/D and bubbles D/E.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  bus
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [3:0] cnt_q, cnt_d;
  logic       md_busy_q, md_busy_d;
  logic       md_done_q, md_done_d;
  logic       stall_rs, stall_rt, stall_md, stall;

  // A producer only blocks D if its value will not be forwardable by the time D needs it.
  function automatic logic raw_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_a3,
    input logic [1:0] e_tnew,
    input logic [4:0] m_a3,
    input logic [1:0] m_tnew
  );
    logic e_hit;
    logic m_hit;
    e_hit = (e_a3 != 5'd0) && (src == e_a3) && (e_tnew > tuse);
    m_hit = (m_a3 != 5'd0) && (src == m_a3) && (m_tnew > tuse);
    return (src != 5'd0) && (tuse != 2'd3) && (e_hit || m_hit);
  endfunction

  always_comb begin
    stall_rs = raw_hazard(bus.D_rs, bus.D_tuse_rs, bus.E_A3, bus.E_tnew, bus.M_A3, bus.M_tnew);
    stall_rt = raw_hazard(bus.D_rt, bus.D_tuse_rt, bus.E_A3, bus.E_tnew, bus.M_A3, bus.M_tnew);
    stall_md = bus.D_is_md && (md_busy_q || bus.E_md_start);
    stall    = !reset && (stall_rs || stall_rt || stall_md);
  end

  assign bus.IFU_en = !stall;
  assign bus.F2D_en = !stall;
  assign bus.D2E_en = 1'b1;
  assign bus.E2M_en = 1'b1;
  assign bus.M2W_en = 1'b1;
  assign bus.flush  = stall;

  // A start that arrives while the unit is occupied is dropped, not queued.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.E_md_start && (cnt_q == 4'd0)) begin
      cnt_d = bus.E_md_is_div ? DIV_LD : MULT_LD;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    md_busy_d = (cnt_d != 4'd0);
    md_done_d = (cnt_q == 4'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      md_busy_q <= md_busy_d;
      md_done_q <= md_done_d;
    end
  end

  assign bus.md_busy = md_busy_q;
  assign bus.md_done = md_done_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  // Default build carries no stall counter.
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized + directed bench for hazard_stall_ctrl against a cycle-indexed reference model.
module tb_hazard_stall_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  // Model: md unit busy for cycles <= busy_end; done pulse on done_cycle.
  int     cyc;
  int     busy_end;
  int     done_cycle;
  longint scnt_m;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic m_haz(input int src, input int tuse, input int ea3, input int etnew,
                                 input int ma3, input int mtnew);
    if (src == 0 || tuse == 3) return 1'b0;
    return (src == ea3 && etnew > tuse) || (src == ma3 && mtnew > tuse);
  endfunction

  task automatic set_in(input int rs, input int rt, input int tur, input int tut, input int ismd,
                        input int ea3, input int etn, input int ma3, input int mtn,
                        input int st, input int dv);
    bus.D_rs        = 5'(rs);
    bus.D_rt        = 5'(rt);
    bus.D_tuse_rs   = 2'(tur);
    bus.D_tuse_rt   = 2'(tut);
    bus.D_is_md     = 1'(ismd);
    bus.E_A3        = 5'(ea3);
    bus.E_tnew      = 2'(etn);
    bus.M_A3        = 5'(ma3);
    bus.M_tnew      = 2'(mtn);
    bus.E_md_start  = 1'(st);
    bus.E_md_is_div = 1'(dv);
  endtask

  // Called at posedge+4 with inputs already applied; checks, advances model, moves to next cycle.
  task automatic run_cycle();
    logic exp_busy;
    logic exp_stall;
    #1;
    exp_busy  = (cyc <= busy_end);
    exp_stall = !reset && (m_haz(int'(bus.D_rs), int'(bus.D_tuse_rs), int'(bus.E_A3), int'(bus.E_tnew),
                                 int'(bus.M_A3), int'(bus.M_tnew)) ||
                           m_haz(int'(bus.D_rt), int'(bus.D_tuse_rt), int'(bus.E_A3), int'(bus.E_tnew),
                                 int'(bus.M_A3), int'(bus.M_tnew)) ||
                           (bus.D_is_md && (exp_busy || bus.E_md_start)));
    chk("IFU_en",  32'(bus.IFU_en),  32'(!exp_stall));
    chk("F2D_en",  32'(bus.F2D_en),  32'(!exp_stall));
    chk("D2E_en",  32'(bus.D2E_en),  32'd1);
    chk("E2M_en",  32'(bus.E2M_en),  32'd1);
    chk("M2W_en",  32'(bus.M2W_en),  32'd1);
    chk("flush",   32'(bus.flush),   32'(exp_stall));
    chk("md_busy", 32'(bus.md_busy), 32'(exp_busy));
    chk("md_done", 32'(bus.md_done), 32'(cyc == done_cycle));
`ifdef HAZARD_STALL_CNT_EN
    chk("stall_cnt", bus.stall_cnt, scnt_m[31:0]);
`endif
    if (reset) begin
      if (busy_end > cyc) busy_end = cyc;
      done_cycle = -1;
      scnt_m     = 0;
    end else begin
      if (bus.E_md_start && !exp_busy) begin
        busy_end   = cyc + (bus.E_md_is_div ? DIV_N : MULT_N);
        done_cycle = busy_end + 1;
      end
      if (exp_stall && scnt_m < 64'hFFFF_FFFF) scnt_m++;
    end
    cyc++;
    @(posedge clk);
    #4;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #4;
    cyc        = 0;
    busy_end   = -1;
    done_cycle = -1;
    scnt_m     = 0;
    run_cycle();
    reset = 1'b0;

    // Load-use, then the producer moves to M where it forwards in time
    set_in(8, 0, 1, 3, 0, 8, 2, 0, 0, 0, 0);
    #1;
    chk("lu_ifu", 32'(bus.IFU_en), 32'd0);
    chk("lu_flush", 32'(bus.flush), 32'd1);
    run_cycle();
    set_in(8, 0, 1, 3, 0, 0, 0, 8, 1, 0, 0);
    #1;
    chk("lu_release", 32'(bus.IFU_en), 32'd1);
    run_cycle();

    // Zero register and unused operand
    set_in(0, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0);
    #1;
    chk("zero_reg", 32'(bus.flush), 32'd0);
    run_cycle();
    set_in(0, 8, 3, 3, 0, 8, 2, 0, 0, 0, 0);
    #1;
    chk("rt_unused", 32'(bus.flush), 32'd0);
    run_cycle();
    set_in(0, 5, 3, 0, 0, 0, 0, 5, 1, 0, 0);
    #1;
    chk("rt_m_haz", 32'(bus.flush), 32'd1);
    run_cycle();

    // Mult sequencing with an md instruction waiting in D
    set_in(0, 0, 3, 3, 1, 0, 0, 0, 0, 1, 0);
    #1;
    chk("mult_start_stall", 32'(bus.IFU_en), 32'd0);
    run_cycle();
    for (int k = 1; k <= 6; k++) begin
      set_in(0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("mult_busy", 32'(bus.md_busy), 32'(k <= 5));
      chk("mult_done", 32'(bus.md_done), 32'(k == 6));
      chk("mult_ifu", 32'(bus.IFU_en), 32'(k == 6));
      run_cycle();
    end

    // Div with an ignored second start at busy cycle 3
    set_in(0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1);
    run_cycle();
    for (int k = 1; k <= 11; k++) begin
      set_in(0, 0, 3, 3, 0, 0, 0, 0, 0, int'(k == 3), 0);
      #1;
      chk("div_busy", 32'(bus.md_busy), 32'(k <= 10));
      chk("div_done", 32'(bus.md_done), 32'(k == 11));
      run_cycle();
    end

    // Reset at busy cycle 4 of a div, with a load-use hazard present during reset
    set_in(0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1);
    run_cycle();
    for (int k = 1; k <= 3; k++) begin
      set_in(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
      run_cycle();
    end
    reset = 1'b1;
    set_in(8, 0, 1, 3, 1, 8, 2, 0, 0, 0, 0);
    #1;
    chk("rst_busy_before", 32'(bus.md_busy), 32'd1);
    chk("rst_no_stall", 32'(bus.IFU_en), 32'd1);
    run_cycle();
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      set_in(0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_busy_after", 32'(bus.md_busy), 32'd0);
      chk("rst_no_done", 32'(bus.md_done), 32'd0);
      chk("rst_md_free", 32'(bus.IFU_en), 32'd1);
      run_cycle();
    end

`ifdef HAZARD_STALL_CNT_EN
    reset = 1'b1;
    set_in(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(8, 0, 1, 3, 0, 8, 2, 0, 0, 0, 0);
      run_cycle();
    end
    set_in(0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0);
    run_cycle();
    for (int k = 0; k < 5; k++) begin
      set_in(0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0);
      run_cycle();
    end
    set_in(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("stall_cnt_8", bus.stall_cnt, 32'd8);
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    #1;
    chk("stall_cnt_rst", bus.stall_cnt, 32'd0);
    run_cycle();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_in(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 1)));
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage F/D/E/M/W core.
- Generates the IFU_en, F2D_en, D2E_en, E2M_en, M2W_en and flush controls that drive the pipeline registers.
- Detects register read-after-write hazards at D using Tuse/Tnew.
- Sequences the multi-cycle multiply/divide unit (HI/LO) with an internal busy counter, stalling D-stage md instructions while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after start (1..15).
- DIV_CYCLES, 10, busy cycles for div/divu after start (1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- D_rs  in  5  rs field of instruction in D.
- D_rt  in  5  rt field of instruction in D.
- D_tuse_rs  in  2  cycles until D instr needs rs (0..2); 3 = rs not read.
- D_tuse_rt  in  2  same for rt.
- D_is_md  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo.
- E_A3  in  5  destination register of instr in E (0 = none).
- E_tnew  in  2  cycles until E instr result is forwardable (0..2).
- M_A3  in  5  destination register of instr in M.
- M_tnew  in  2  same for M (0..1).
- E_md_start  in  1  mult/div in E launching this cycle.
- E_md_is_div  in  1  1 = div/divu, 0 = mult/multu; valid with E_md_start.
- IFU_en  out  1  PC update enable.
- F2D_en  out  1  F/D register enable.
- D2E_en  out  1  D/E register enable.
- E2M_en  out  1  E/M register enable.
- M2W_en  out  1  M/W register enable.
- flush  out  1  clear D/E register to nop (bubble).
- md_busy  out  1  mult/div unit occupied.
- md_done  out  1  one-cycle pulse when result becomes available.

Behaviour:
- Register hazard, combinational:
  - stall_rs = D_rs!=0 && D_tuse_rs!=3 && ((D_rs==E_A3 && E_tnew>D_tuse_rs) || (D_rs==M_A3 && M_tnew>D_tuse_rs)).
  - stall_rt is defined the same way for rt.
  - An A3 of 0 never matches.
- md hazard, combinational: stall_md = D_is_md && (md_busy || E_md_start).
- stall = stall_rs | stall_rt | stall_md.
- Outputs:
  - stall=1: IFU_en=0, F2D_en=0, flush=1, D2E_en=1.
  - Otherwise: IFU_en=F2D_en=D2E_en=1, flush=0.
  - E2M_en=M2W_en=1 always.
- md counter (4-bit cnt), sequential:
  - On E_md_start with cnt==0, load MULT_CYCLES or DIV_CYCLES per E_md_is_div.
  - Else, if cnt!=0, decrement by 1.
  - E_md_start while cnt!=0 is ignored; the counter is not reloaded.
- md_busy = (cnt!=0), registered state.
  - Busy begins the cycle after start.
  - Busy lasts exactly N cycles.
- md_done: registered pulse, 1 for the single cycle after cnt transitions 1→0.
- Reset:
  - cnt=0, md_busy=0, md_done=0.
  - While reset is high, stall is forced 0: IFU_en=F2D_en=D2E_en=1, flush=0.
  - Reset mid-operation abandons the operation; no md_done.
- Simultaneous events:
  - Register hazard and md hazard together produce a single stall.
  - E_md_start in the same cycle cnt reaches 0 loads the new count; md_done still pulses for the old operation.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0].
  - Counts cycles with stall=1.
  - Cleared by reset.
  - Saturates at 32'hFFFFFFFF.
- Undefined: no port, no counter; the rest of the behaviour is identical.

Test Plan:
- Load-use: E_A3=8, E_tnew=2, D_rs=8, D_tuse_rs=1 → stall=1 (IFU_en=0, F2D_en=0, flush=1) that cycle. Next cycle E_A3=0, M_A3=8, M_tnew=1 → stall=0.
- Zero register / unused operand:
  - E_A3=0, D_rs=0, E_tnew=2 → stall=0.
  - D_rt=8=E_A3 with D_tuse_rt=3 → stall=0.
- Mult sequencing: E_md_start=1, E_md_is_div=0 at cycle t → md_busy=1 for cycles t+1..t+5, md_done=1 at t+6 only. D_is_md=1 stalls cycles t..t+5 and releases at t+6.
- Div sequencing: E_md_start=1, E_md_is_div=1 → md_busy for 10 cycles. A second E_md_start at busy cycle 3 → ignored; md_busy still drops after cycle 10.
- Reset mid-div: assert reset at busy cycle 4 → next cycle md_busy=0, cnt=0, md_done never pulses, stall=0.
- HAZARD_STALL_CNT_EN: 3 load-use stalls plus a 5-cycle md stall → stall_cnt=8; reset → stall_cnt=0.
